bus_io_responder: RTL and testbench

BUS_IO_RESPONDER -- requirements
Module: bus_io_responder

---
 rtl/bus_io_responder_pkg.sv | 36 +++
 rtl/bus_io_responder_stream_fifo.sv | 55 +++++
 rtl/bus_io_responder.sv | 132 +++++++++++++
 tb/tb_bus_io_responder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_io_responder_pkg.sv
// Shared address map, STATUS bit positions and address decode for the bus I/O responder.
package bus_io_responder_pkg;

    localparam logic [31:0] ADDR_RAM_BASE = 32'h0000_0000;
    localparam logic [31:0] ADDR_OUT_DATA = 32'h000F_FFF0;
    localparam logic [31:0] ADDR_STATUS   = 32'h000F_FFF1;
    localparam logic [31:0] ADDR_IN_DATA  = 32'h000F_FFF2;
    localparam logic [31:0] ADDR_TIMER    = 32'h000F_FFF3;

    localparam int ST_FIFO_FULL  = 0;
    localparam int ST_FIFO_EMPTY = 1;
    localparam int ST_IN_FULL    = 2;
    localparam int ST_OUT_OVF    = 3;
    localparam int ST_IN_OVR     = 4;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_OUT_DATA,
        REG_STATUS,
        REG_IN_DATA,
        REG_TIMER,
        REG_NONE
    } region_e;

    function automatic region_e decode_addr(input logic [31:0] addr, input logic [31:0] ram_words);
        region_e r;
        r = REG_NONE;
        if (addr < ADDR_RAM_BASE + ram_words) r = REG_RAM;
        else if (addr == ADDR_OUT_DATA)       r = REG_OUT_DATA;
        else if (addr == ADDR_STATUS)         r = REG_STATUS;
        else if (addr == ADDR_IN_DATA)        r = REG_IN_DATA;
        else if (addr == ADDR_TIMER)          r = REG_TIMER;
        return r;
    endfunction

endpackage

// File: rtl/bus_io_responder_stream_fifo.sv
// Output stream FIFO: registered head (no bypass), drop-on-full unless a pop frees a slot.
module stream_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_WIDTH-1:0]      push_data,
    input  logic                       ready,
    output logic [DATA_WIDTH-1:0]      head,
    output logic                       valid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drop
);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic                  pop;
    logic                  accept;

    assign empty  = (count == '0);
    assign full   = (count == (PW+1)'(DEPTH));
    assign valid  = !empty;
    assign pop    = valid && ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;
    assign head   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset && accept) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/bus_io_responder.sv
// Zero-wait-state bus slave: data RAM, output stream FIFO, input mailbox, free-running timer.
module bus_io_responder
    import bus_io_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    inout  wire  [DATA_WIDTH-1:0] bus_data,
    input  logic                  read,
    input  logic                  write,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_strobe,
    output logic                  in_full
);
    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    region_e               region;
    logic                  rd_en;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] status_word;
    logic [RAM_AW-1:0]     ram_idx;
    logic [DATA_WIDTH-1:0] ram [RAM_WORDS];
    logic [DATA_WIDTH-1:0] mailbox;
    logic [DATA_WIDTH-1:0] timer;
    logic                  out_ovf;
    logic                  in_ovr;
    logic                  fifo_push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_drop;
    logic [CW-1:0]         fifo_count;
    logic                  mbox_read;
    logic                  status_wr;
    logic                  ovr_event;

    assign region  = decode_addr(32'(bus_addr), 32'(RAM_WORDS));
    assign ram_idx = bus_addr[RAM_AW-1:0];

    // Write takes priority: read+write together is a write and the bus stays released.
    assign wr_en   = write;
    assign rd_en   = read && !write;
    assign wr_data = bus_data;
    assign bus_data = rd_en ? rd_data : 'z;

    assign fifo_push = wr_en && (region == REG_OUT_DATA);
    assign mbox_read = rd_en && (region == REG_IN_DATA);
    assign status_wr = wr_en && (region == REG_STATUS);
    // A strobe that coincides with the mailbox being read replaces consumed data, not unread data.
    assign ovr_event = in_strobe && in_full && !mbox_read;

    always_comb begin
        status_word                = '0;
        status_word[ST_FIFO_FULL]  = fifo_full;
        status_word[ST_FIFO_EMPTY] = fifo_empty;
        status_word[ST_IN_FULL]    = in_full;
        status_word[ST_OUT_OVF]    = out_ovf;
        status_word[ST_IN_OVR]     = in_ovr;
    end

    always_comb begin
        rd_data = '0;
        case (region)
            REG_RAM:      rd_data = ram[ram_idx];
            REG_OUT_DATA: rd_data = DATA_WIDTH'(fifo_count);
            REG_STATUS:   rd_data = status_word;
            REG_IN_DATA:  rd_data = mailbox;
            REG_TIMER:    rd_data = timer;
            default:      rd_data = '0;
        endcase
    end

    stream_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (wr_data),
        .ready     (out_ready),
        .head      (out_data),
        .valid     (out_valid),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .drop      (fifo_drop)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_full <= 1'b0;
            mailbox <= '0;
            out_ovf <= 1'b0;
            in_ovr  <= 1'b0;
            timer   <= '0;
        end else begin
            if (in_strobe) begin
                mailbox <= in_data;
                in_full <= 1'b1;
            end else if (mbox_read) begin
                in_full <= 1'b0;
            end

            // Set events win over a software clear in the same cycle.
            if (fifo_drop)                        out_ovf <= 1'b1;
            else if (status_wr && wr_data[ST_OUT_OVF]) out_ovf <= 1'b0;

            if (ovr_event)                        in_ovr <= 1'b1;
            else if (status_wr && wr_data[ST_IN_OVR])  in_ovr <= 1'b0;

            if (wr_en && (region == REG_TIMER)) timer <= wr_data;
            else                                timer <= timer + 1'b1;
        end
    end

    // RAM contents survive reset; only writes outside reset land.
    always_ff @(posedge clk) begin
        if (reset && wr_en && (region == REG_RAM)) ram[ram_idx] <= wr_data;
    end

endmodule

// File: tb/tb_bus_io_responder.sv
// Scoreboard bench: expected bus reads and stream words are queued at issue, monitors compare.
module tb_bus_io_responder;
    localparam int AW = 20;
    localparam int DW = 16;
    localparam logic [AW-1:0] A_OUT = 20'hFFFF0;
    localparam logic [AW-1:0] A_ST  = 20'hFFFF1;
    localparam logic [AW-1:0] A_IN  = 20'hFFFF2;
    localparam logic [AW-1:0] A_TMR = 20'hFFFF3;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] bus_addr;
    wire  [DW-1:0] bus_data;
    logic          read;
    logic          write;
    logic          drive;
    logic [DW-1:0] drive_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] in_data;
    logic          in_strobe;
    logic          in_full;
    logic [DW-1:0] sample;

    int compared   = 0;
    int mismatched = 0;
    logic [DW-1:0] rd_q[$];
    logic [DW-1:0] st_q[$];

    always #5 clk = ~clk;

    assign bus_data = drive ? drive_data : 'z;

    bus_io_responder #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RAM_WORDS  (256),
        .FIFO_DEPTH (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus_addr  (bus_addr),
        .bus_data  (bus_data),
        .read      (read),
        .write     (write),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .in_data   (in_data),
        .in_strobe (in_strobe),
        .in_full   (in_full)
    );

    function automatic void check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endfunction

    // Bus read monitor
    always @(negedge clk) begin
        if (read && !write) begin
            if (rd_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL rd_unexpected @%h: got %h, expected no read", bus_addr, bus_data);
            end else begin
                check($sformatf("rd@%h", bus_addr), bus_data, rd_q.pop_front());
            end
        end
    end

    // Stream monitor
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (st_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL pop_unexpected: got %h, expected no pop", out_data);
            end else begin
                check("pop", out_data, st_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        read  = 1'b0;
        write = 1'b0;
        drive = 1'b0;
    endtask

    task automatic bus_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus_addr = a; drive_data = d; drive = 1'b1; write = 1'b1; read = 1'b0;
        tick();
        bus_idle();
    endtask

    task automatic bus_rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        bus_addr = a; read = 1'b1; write = 1'b0; drive = 1'b0;
        rd_q.push_back(exp);
        tick();
        bus_idle();
    endtask

    task automatic strobe(input logic [DW-1:0] d);
        in_data = d; in_strobe = 1'b1;
        tick();
        in_strobe = 1'b0;
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int n = 0; n < 40 && st_q.size() != 0; n++) tick();
        check({name, "_left"}, 16'(st_q.size()), 16'd0);
        check({name, "_valid"}, 16'(out_valid), 16'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; bus_addr = '0; drive_data = '0; out_ready = 1'b0;
        in_data = '0; in_strobe = 1'b0;
        bus_idle();
        tick(); tick();
        reset = 1'b1;
        check("rst_out_valid", 16'(out_valid), 16'd0);
        check("rst_in_full", 16'(in_full), 16'd0);
        check("rst_out_data", out_data, 16'h0000);
        bus_rd(A_ST, 16'h0002);
        bus_rd(A_TMR, 16'h0001);
        bus_rd(A_OUT, 16'h0000);

        // RAM, reset preserving RAM, unmapped accesses
        bus_wr(20'h00006, 16'h5A5A);
        bus_wr(20'h00005, 16'h1234);
        reset = 1'b0;
        bus_wr(20'h00006, 16'hFFFF);
        reset = 1'b1;
        bus_rd(20'h00005, 16'h1234);
        bus_rd(20'h00006, 16'h5A5A);
        bus_rd(20'h12345, 16'h0000);
        bus_rd(20'h00100, 16'h0000);
        bus_rd(20'hFFFF4, 16'h0000);
        bus_wr(20'h00106, 16'hDEAD);
        bus_rd(20'h00006, 16'h5A5A);
        bus_addr = 20'h00007; drive_data = 16'h7777; drive = 1'b1; write = 1'b1; read = 1'b1;
        @(negedge clk);
        check("rw_bus", bus_data, 16'h7777);
        tick();
        bus_idle();
        bus_rd(20'h00007, 16'h7777);

        // FIFO fill, overflow drop, clear, push-while-full-with-pop
        for (int i = 1; i <= 8; i++) begin
            bus_wr(A_OUT, 16'(16'hA000 + i));
            st_q.push_back(16'(16'hA000 + i));
        end
        bus_rd(A_ST, 16'h0001);
        bus_rd(A_OUT, 16'h0008);
        check("full_head", out_data, 16'hA001);
        bus_wr(A_OUT, 16'hA009);
        bus_rd(A_ST, 16'h0009);
        bus_rd(A_OUT, 16'h0008);
        bus_wr(A_ST, 16'h0008);
        bus_rd(A_ST, 16'h0001);
        out_ready = 1'b1;
        st_q.push_back(16'hBEEF);
        bus_wr(A_OUT, 16'hBEEF);
        out_ready = 1'b0;
        bus_rd(A_OUT, 16'h0008);
        bus_rd(A_ST, 16'h0001);
        drain("drain1");
        bus_rd(A_ST, 16'h0002);

        // Mailbox
        strobe(16'h00AA);
        check("mb_full_aa", 16'(in_full), 16'd1);
        strobe(16'h00BB);
        bus_rd(A_ST, 16'h0016);
        in_data = 16'h00CC; in_strobe = 1'b1;
        bus_rd(A_IN, 16'h00BB);
        in_strobe = 1'b0;
        check("mb_full_cc", 16'(in_full), 16'd1);
        bus_rd(A_ST, 16'h0016);
        bus_rd(A_IN, 16'h00CC);
        check("mb_empty", 16'(in_full), 16'd0);
        strobe(16'h00DD);
        bus_rd(A_ST, 16'h0016);
        bus_wr(A_ST, 16'h0010);
        bus_rd(A_ST, 16'h0006);
        in_data = 16'h00EE; in_strobe = 1'b1;
        bus_wr(A_ST, 16'h0010);
        in_strobe = 1'b0;
        bus_rd(A_ST, 16'h0016);

        // Timer wrap
        bus_wr(A_TMR, 16'hFFFE);
        tick(); tick(); tick();
        bus_rd(A_TMR, 16'h0001);

        // Both sticky bits set, then cleared together
        for (int i = 1; i <= 9; i++) begin
            bus_wr(A_OUT, 16'(16'hD000 + i));
            if (i <= 8) st_q.push_back(16'(16'hD000 + i));
        end
        bus_rd(A_ST, 16'h001D);
        bus_wr(A_ST, 16'h0018);
        bus_rd(A_ST, 16'h0005);
        drain("drain2");

        // Reset mid-stream wins over bus write and strobe
        for (int i = 1; i <= 3; i++) bus_wr(A_OUT, 16'(16'hC000 + i));
        check("pre_rst_valid", 16'(out_valid), 16'd1);
        check("pre_rst_in_full", 16'(in_full), 16'd1);
        reset = 1'b0; in_data = 16'h0055; in_strobe = 1'b1;
        bus_addr = A_TMR; drive_data = 16'h1234; drive = 1'b1; write = 1'b1;
        tick();
        reset = 1'b1; in_strobe = 1'b0;
        bus_idle();
        bus_addr = A_ST;
        #1;
        check("mid_rst_valid", 16'(out_valid), 16'd0);
        check("mid_rst_in_full", 16'(in_full), 16'd0);
        sample = bus_data;
        compared++;
        if (!($isunknown(sample) || sample == '0)) begin
            mismatched++;
            $display("FAIL hiz: bus_data %h, required high-Z", sample);
        end
        bus_rd(A_TMR, 16'h0000);
        bus_rd(A_ST, 16'h0002);
        bus_rd(A_OUT, 16'h0000);
        bus_rd(A_IN, 16'h0000);
        bus_rd(20'h00005, 16'h1234);
        tick();
        check("rd_q_left", 16'(rd_q.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
